// File: rtl/bmac_operand_packer.sv
// bmac_operand_packer
//
// Packs a stream of operand-pair beats into the two operand words used by
// the BMAC core. Each accepted beat carries one LANE_WIDTH-bit nibble per
// operand. LANES beats fill a word. An in_last beat closes the word early,
// and the lanes that were not filled read as zero.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. valid does not depend on ready. Once out_valid is raised, the
// payload (bmac_in_0, bmac_in_1, out_lanes) holds stable until that edge.
// in_ready is combinational from out_ready only.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid, in_ready   input beat handshake
//   in_a, in_b           operand-0 / operand-1 nibbles for this beat
//   in_last              close the current word after this beat
//   out_valid, out_ready packed-pair handshake
//   bmac_in_0, bmac_in_1 packed operand words
//   out_lanes            number of filled lanes in the pair (1..LANES)
//
// Build option:
//   BMAC_PACK_MSB_FIRST_EN  the first beat lands in the most significant
//                           lane, and padding fills the low lanes. When it is
//                           undefined, the first beat lands in lane 0 (bits
//                           LANE_WIDTH-1:0), and padding fills the high lanes.

module bmac_operand_packer #(
    parameter  int LANE_WIDTH = 4,
    parameter  int LANES      = 8,
    localparam int IN_WIDTH   = LANE_WIDTH * LANES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANE_WIDTH-1:0] in_a,
    input  logic [LANE_WIDTH-1:0] in_b,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IN_WIDTH-1:0]   bmac_in_0,
    output logic [IN_WIDTH-1:0]   bmac_in_1,
    output logic [3:0]            out_lanes
);

    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LANES - 1);

    logic [CNT_W-1:0]    cnt;
    logic [IN_WIDTH-1:0] asm_0;
    logic [IN_WIDTH-1:0] asm_1;

    logic                accept;
    logic                complete;
    logic [CNT_W-1:0]    lane_idx;
    logic [IN_WIDTH-1:0] merged_0;
    logic [IN_WIDTH-1:0] merged_1;

    // Stall only while a held pair is not being taken this cycle.
    assign in_ready = !out_valid || out_ready;

    always_comb begin
        accept   = in_valid && in_ready;
        complete = accept && ((cnt == LAST_CNT) || in_last);

`ifdef BMAC_PACK_MSB_FIRST_EN
        lane_idx = LAST_CNT - cnt;
`else
        lane_idx = cnt;
`endif

        // The assembly registers are cleared at each word boundary. Lanes not
        // yet written are therefore already zero, which supplies the padding
        // for an early-closed word.
        merged_0 = asm_0;
        merged_1 = asm_1;
        for (int i = 0; i < LANES; i++) begin
            if (lane_idx == CNT_W'(i)) begin
                merged_0[i*LANE_WIDTH +: LANE_WIDTH] = in_a;
                merged_1[i*LANE_WIDTH +: LANE_WIDTH] = in_b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            asm_0     <= '0;
            asm_1     <= '0;
            out_valid <= 1'b0;
            bmac_in_0 <= '0;
            bmac_in_1 <= '0;
            out_lanes <= '0;
        end else begin
            if (complete) begin
                // A completing beat can only be accepted when the output slot
                // is free or drains this cycle. Loading the new pair therefore
                // never overwrites an untaken one, and out_valid stays set.
                bmac_in_0 <= merged_0;
                bmac_in_1 <= merged_1;
                out_lanes <= 4'(cnt) + 4'd1;
                out_valid <= 1'b1;
                asm_0     <= '0;
                asm_1     <= '0;
                cnt       <= '0;
            end else begin
                if (accept) begin
                    asm_0 <= merged_0;
                    asm_1 <= merged_1;
                    cnt   <= cnt + CNT_W'(1);
                end
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule
